fetch_queue: RTL and testbench

- Instruction fetch stage for the pipelined WISC-15 core, directly upstream of decode/control.
- Owns the fetch PC and drives the synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions, each tagged with its PC, in a small FIFO.
- Presents the buffered instructions to decode over a valid/ready handshake.
- Handles redirects (branch/call/ret) and halt.

---
 rtl/fetch_queue.sv | 157 +++++++++++++++
 tb/tb_fetch_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - WISC-15 instruction fetch stage: PC, I-mem issue, tagged FIFO to decode (optional macro FETCH_BYPASS_EN)
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_rd_en,
    input  logic [15:0]       im_instr,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [15:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_halted;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_pend_pc;
    logic              r_pending;

    logic [15:0]       r_mem_instr [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc    [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_run;
    logic              w_flush;
    logic              w_issue;
    logic              w_resp;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_occ;
`ifdef FETCH_BYPASS_EN
    logic              w_byp;
`endif

    // Slots already committed = buffered entries plus the one response in flight;
    // issuing only while this is below DEPTH means a push never meets a full FIFO.
    assign w_run   = (r_state == S_RUN);
    assign w_flush = w_run & (redirect | halt);
    assign w_occ   = r_count + CNT_W'(r_pending);
    assign w_issue = !rst & w_run & !halt & (redirect | (w_occ < CNT_W'(DEPTH)));
    assign w_resp  = r_pending & !w_flush;
    assign w_empty = (r_count == '0);

    assign im_addr  = redirect ? redirect_pc : r_fetch_pc;
    assign im_rd_en = w_issue;
    assign halted   = r_halted;

`ifdef FETCH_BYPASS_EN
    // A response landing on an empty FIFO goes straight to decode.
    assign w_byp  = !rst & w_resp & w_empty;
    assign w_push = w_resp & !(w_byp & instr_ready);
    assign w_pop  = instr_valid & instr_ready & !w_flush & !w_byp;
`else
    assign w_push = w_resp;
    assign w_pop  = instr_valid & instr_ready & !w_flush;
`endif

    // Head presentation: FIFO head register, overridden by the bypass path when enabled.
    always_comb begin
        instr_valid = !w_empty;
        instr_out   = r_mem_instr[r_rd_ptr];
        instr_pc    = r_mem_pc[r_rd_ptr];
`ifdef FETCH_BYPASS_EN
        if (w_byp) begin
            instr_valid = 1'b1;
            instr_out   = im_instr;
            instr_pc    = r_pend_pc;
        end
`endif
    end

    // Run/halt state machine plus fetch PC and in-flight request tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_halted   <= 1'b0;
            r_fetch_pc <= '0;
            r_pend_pc  <= '0;
            r_pending  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (halt) begin
                        r_state   <= S_HALTED;
                        r_halted  <= 1'b1;
                        r_pending <= 1'b0;
                    end else begin
                        r_pending <= w_issue;
                        if (w_issue) begin
                            r_pend_pc  <= im_addr;
                            r_fetch_pc <= im_addr + ADDR_W'(1);
                        end
                    end
                end
                S_HALTED: begin
                    r_halted  <= 1'b1;
                    r_pending <= 1'b0;
                end
                default: begin
                    r_state   <= S_HALTED;
                    r_halted  <= 1'b1;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    // Instruction FIFO: flushed on redirect/halt, simultaneous push and pop allowed at any fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= im_instr;
                r_mem_pc[r_wr_ptr]    <= r_pend_pc;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue against a queue-based reference model
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] im_instr = 16'h0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halt = 1'b0;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        halted;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .im_addr     (im_addr),
        .im_rd_en    (im_rd_en),
        .im_instr    (im_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // memory model: IM[a] = 0xA000 + a, returned the cycle after the request
    bit          mem_v = 1'b0;
    logic [15:0] mem_a = 16'h0;

    // reference model: buffered PCs in order, one in-flight request, fetch PC, halt flag
    logic [15:0] q_pc[$];
    bit          m_pend = 1'b0;
    logic [15:0] m_pend_pc = 16'h0;
    logic [15:0] m_fpc = 16'h0;
    bit          m_halted = 1'b0;

    bit          e_valid, e_rden, e_halted;
    logic [15:0] e_pc, e_addr;
    logic [50:0] obs, expv;

    // one clock of stimulus; leaves this cycle's expectations in e_*
    task automatic step(input bit rs, input bit rd, input logic [15:0] rpc, input bit hl, input bit rdy);
        bit byp;
        @(negedge clk);
        cyc++;
        im_instr    = mem_v ? (16'hA000 + mem_a) : 16'($urandom);
        rst         = rs;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        instr_ready = rdy;
        #1;
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = !rs && !m_halted && !hl && !rd && m_pend && (q_pc.size() == 0);
`endif
        e_valid  = (q_pc.size() != 0) || byp;
        e_pc     = (q_pc.size() != 0) ? q_pc[0] : m_pend_pc;
        e_rden   = !rs && !m_halted && !hl && (rd || ((q_pc.size() + int'(m_pend)) < DEPTH));
        e_addr   = rd ? rpc : m_fpc;
        e_halted = m_halted;
        mem_v = (im_rd_en === 1'b1);
        mem_a = im_addr;
        if (rs) begin
            q_pc.delete();
            m_pend = 1'b0; m_pend_pc = 16'h0; m_fpc = 16'h0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_pend = 1'b0;
        end else if (hl) begin
            m_halted = 1'b1;
            q_pc.delete();
            m_pend = 1'b0;
        end else if (rd) begin
            q_pc.delete();
            m_pend = 1'b1; m_pend_pc = rpc; m_fpc = rpc + 16'h1;
        end else begin
            if (byp) begin
                if (!rdy) q_pc.push_back(m_pend_pc);
            end else begin
                if (e_valid && rdy) void'(q_pc.pop_front());
                if (m_pend) q_pc.push_back(m_pend_pc);
            end
            if (e_rden) begin
                m_pend_pc = m_fpc;
                m_fpc     = m_fpc + 16'h1;
            end
            m_pend = e_rden;
        end
        obs  = {instr_valid, e_valid ? {instr_pc, instr_out} : 32'h0, im_rd_en, e_rden ? im_addr : 16'h0, halted};
        expv = {e_valid, e_valid ? {e_pc, e_pc + 16'hA000} : 32'h0, e_rden, e_rden ? e_addr : 16'h0, e_halted};
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        vecs++;
        if ({instr_valid, im_rd_en, halted, instr_out, instr_pc} !== 35'h0) begin
            errs++;
            $display("FAIL reset_state cyc %0d: got v=%b rd=%b h=%b out=%h pc=%h, expected all zero",
                     cyc, instr_valid, im_rd_en, halted, instr_out, instr_pc);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
            vecs++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL stream cyc %0d: got %h expected %h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_stall_release();
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 22; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0, (i >= 9));
            vecs++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL stall_release cyc %0d: got %h expected %h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_redirect();
        bit rd;
        logic [15:0] tgt;
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            rd  = (i == 8) || (i == 14) || (i == 15);
            tgt = (i == 14) ? 16'h0100 : 16'h0040;
            step(1'b0, rd, tgt, 1'b0, (i < 5) || (i >= 9 && i != 17));
            vecs++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL redirect cyc %0d: got %h expected %h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i == 0), 16'hFFFE, 1'b0, 1'b1);
            vecs++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL wrap cyc %0d: got %h expected %h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 22; i++) begin
            if (i == 3)
                step(1'b0, 1'b1, 16'h0010, 1'b1, 1'b1);
            else if (i == 12)
                step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
            else
                step(1'b0, ($urandom_range(0, 3) == 0), 16'($urandom), (i > 3 && i < 12 && $urandom_range(0, 1) == 1),
                     $urandom_range(0, 1) == 1);
            vecs++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL halt cyc %0d: got %h expected %h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), 16'($urandom),
                 ($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0));
            vecs++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL random cyc %0d: got %h expected %h", cyc, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_release();
        test_redirect();
        test_wrap();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
